// File: rtl/mult_job_sequencer.sv
// Bus-master sequencer for the GPIO-emulated multiplier: writes both operands and start,
// polls status until done (or timeout), reads W and L, and returns them on a result port.
module mult_job_sequencer #(
  parameter int STROBE_CYCLES = 2,
  parameter int POLL_GAP      = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [23:0] job_a1,
  input  logic [23:0] job_a2,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_w,
  output logic [5:0]  res_l,
  output logic        res_ovf,
  output logic        res_timeout,
  output logic [15:0] job_count,
  output logic [3:0]  dbg_state
);

  localparam logic [15:0] ADDR_A1   = 16'h0380;
  localparam logic [15:0] ADDR_A2   = 16'h0388;
  localparam logic [15:0] ADDR_W    = 16'h0390;
  localparam logic [15:0] ADDR_L    = 16'h0398;
  localparam logic [15:0] ADDR_CTRL = 16'h03A0;

  localparam logic [7:0] ACC_LAST    = 8'(STROBE_CYCLES + 1);
  localparam logic [7:0] GAP_LAST    = 8'((POLL_GAP > 0) ? (POLL_GAP - 1) : 0);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, WR_A1, WR_A2, WR_START, POLL, GAP, RD_W, RD_L, OUT
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [7:0]  poll_cnt_q, poll_cnt_d;
  logic [23:0] a1_q, a1_d, a2_q, a2_d;
  logic        job_ready_q, job_ready_d;
  logic [31:0] res_w_q, res_w_d;
  logic [5:0]  res_l_q, res_l_d;
  logic        res_ovf_q, res_ovf_d;
  logic        res_timeout_q, res_timeout_d;
  logic [15:0] job_count_q, job_count_d;

  logic        in_access, bus_rd, bus_wr, acc_last, strobe_phase;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;

  // Both ports use strict valid/ready: a transfer happens on the rising edge where
  // valid && ready are both high; the offering side keeps its payload stable until then.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    poll_cnt_d    = poll_cnt_q;
    a1_d          = a1_q;
    a2_d          = a2_q;
    res_w_d       = res_w_q;
    res_l_d       = res_l_q;
    res_ovf_d     = res_ovf_q;
    res_timeout_d = res_timeout_q;
    job_count_d   = job_count_q;
    in_access     = 1'b0;
    bus_rd        = 1'b0;
    bus_wr        = 1'b0;
    bus_addr      = 16'h0;
    bus_wdata     = 32'h0;
    acc_last      = (phase_q == ACC_LAST);

    case (state_q)
      IDLE: begin
        if (job_valid && job_ready_q) begin
          a1_d          = job_a1;
          a2_d          = job_a2;
          res_ovf_d     = 1'b0;
          res_timeout_d = 1'b0;
          phase_d       = 8'd0;
          state_d       = WR_A1;
        end
      end
      WR_A1: begin
        in_access = 1'b1;
        bus_wr    = 1'b1;
        bus_addr  = ADDR_A1;
        bus_wdata = {8'h0, a1_q};
        if (acc_last) state_d = WR_A2;
      end
      WR_A2: begin
        in_access = 1'b1;
        bus_wr    = 1'b1;
        bus_addr  = ADDR_A2;
        bus_wdata = {8'h0, a2_q};
        if (acc_last) state_d = WR_START;
      end
      WR_START: begin
        in_access = 1'b1;
        bus_wr    = 1'b1;
        bus_addr  = ADDR_CTRL;
        bus_wdata = 32'h1;
        if (acc_last) state_d = POLL;
      end
      POLL: begin
        in_access = 1'b1;
        bus_rd    = 1'b1;
        bus_addr  = ADDR_CTRL;
        if (acc_last) begin
          poll_cnt_d = poll_cnt_q + 8'd1;
          if (sdata_in[1]) begin
            res_ovf_d = ~sdata_in[0];
            state_d   = RD_W;
          end else if (poll_cnt_d == TIMEOUT_CNT) begin
            res_timeout_d = 1'b1;
            res_w_d       = 32'h0;
            res_l_d       = 6'h0;
            res_ovf_d     = 1'b0;
            state_d       = OUT;
          end else begin
            state_d = (POLL_GAP > 0) ? GAP : POLL;
          end
        end
      end
      GAP: begin
        // Gap cycles reuse the phase counter; the bus stays idle here.
        if (phase_q == GAP_LAST) begin
          phase_d = 8'd0;
          state_d = POLL;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      RD_W: begin
        in_access = 1'b1;
        bus_rd    = 1'b1;
        bus_addr  = ADDR_W;
        if (acc_last) begin
          res_w_d = sdata_in;
          state_d = RD_L;
        end
      end
      RD_L: begin
        in_access = 1'b1;
        bus_rd    = 1'b1;
        bus_addr  = ADDR_L;
        if (acc_last) begin
          res_l_d = sdata_in[5:0];
          state_d = OUT;
        end
      end
      OUT: begin
        if (res_ready) begin
          job_count_d = job_count_q + 16'd1;
          poll_cnt_d  = 8'd0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (in_access) phase_d = acc_last ? 8'd0 : phase_q + 8'd1;
    job_ready_d = (state_d == IDLE);
  end

  // Access phases: 0 = setup, 1..STROBE_CYCLES = strobe high, ACC_LAST = hold/sample.
  assign strobe_phase = in_access && (phase_q != 8'd0) && !acc_last;
  assign saddress     = bus_addr;
  assign sdata_out    = bus_wdata;
  assign srd          = bus_rd && strobe_phase;
  assign swr          = bus_wr && strobe_phase;

  assign job_ready   = job_ready_q;
  assign res_valid   = (state_q == OUT);
  assign res_w       = res_w_q;
  assign res_l       = res_l_q;
  assign res_ovf     = res_ovf_q;
  assign res_timeout = res_timeout_q;
  assign job_count   = job_count_q;
  assign dbg_state   = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      phase_q       <= 8'd0;
      poll_cnt_q    <= 8'd0;
      a1_q          <= 24'h0;
      a2_q          <= 24'h0;
      job_ready_q   <= 1'b0;
      res_w_q       <= 32'h0;
      res_l_q       <= 6'h0;
      res_ovf_q     <= 1'b0;
      res_timeout_q <= 1'b0;
      job_count_q   <= 16'h0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      poll_cnt_q    <= poll_cnt_d;
      a1_q          <= a1_d;
      a2_q          <= a2_d;
      job_ready_q   <= job_ready_d;
      res_w_q       <= res_w_d;
      res_l_q       <= res_l_d;
      res_ovf_q     <= res_ovf_d;
      res_timeout_q <= res_timeout_d;
      job_count_q   <= job_count_d;
    end
  end

endmodule
